mod53_serial_reducer: RTL and testbench

//  Reduces a wide unsigned operand to its residue mod 53, one 6-bit digit per cycle, MSB digit first.

---
 rtl/mod53_pkg.sv | 34 +++
 rtl/mod53_times64_lut.sv | 19 +
 rtl/mod53_serial_reducer.sv | 110 +++++++++++
 tb/tb_mod53_serial_reducer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mod53_pkg.sv
// Shared types and arithmetic helpers for the mod-53 serial reducer datapath.
package mod53_pkg;

  localparam int MOD     = 53;
  localparam int DIGIT_W = 6;
  localparam int RES_W   = 6;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } red_state_e;

  // Folds a sum below 159 back into 0..52 with at most two conditional subtracts.
  function automatic res_t reduce_lt159(input logic [7:0] s);
    logic [7:0] r;
    if (s >= 8'd106) begin
      r = s - 8'd106;
    end else if (s >= 8'd53) begin
      r = s - 8'd53;
    end else begin
      r = s;
    end
    return r[RES_W-1:0];
  endfunction

  // Times-64 residue of a constant, used to fill the LUT at elaboration.
  function automatic res_t times64_const(input int a);
    return res_t'((a * 64) % MOD);
  endfunction

endpackage

// File: rtl/mod53_times64_lut.sv
// Combinational (a*64) mod 53 table; inputs 53..63 are unreachable and map to 0.
module mod53_times64_lut
  import mod53_pkg::*;
(
  input  logic [RES_W-1:0] lut_in,
  output logic [RES_W-1:0] lut_out
);

  // Table lookup: every reachable residue selects its constant-folded product.
  always_comb begin
    lut_out = '0;
    for (int i = 0; i < MOD; i++) begin
      if (lut_in == RES_W'(i)) begin
        lut_out = times64_const(i);
      end
    end
  end

endmodule

// File: rtl/mod53_serial_reducer.sv
// Serial mod-53 reducer: consumes one 6-bit digit per cycle, MSB digit first,
// accumulating acc = (acc*64 + digit) mod 53.
// Optional feature macro: MOD53_ZERO_FLAG_EN adds the out_zero divisibility flag.
module mod53_serial_reducer
  import mod53_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MOD53_ZERO_FLAG_EN
  output logic              out_zero,
`endif
  output logic [RES_W-1:0]  out_residue
);

  localparam int NDIG  = DATA_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if ((DATA_W % DIGIT_W) != 0) begin : g_bad_width
    $error("mod53_serial_reducer: DATA_W must be a multiple of 6");
  end

  red_state_e        state_q, state_d;
  res_t              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic [DIGIT_W-1:0] digit;
  res_t               t64_out;
  logic [7:0]         step_sum;

  assign digit    = shreg_q[DATA_W-1 -: DIGIT_W];
  assign step_sum = {2'b00, t64_out} + {2'b00, digit};

  mod53_times64_lut u_t64 (
    .lut_in  (acc_q),
    .lut_out (t64_out)
  );

  // Handshakes and result decode come from registered state only.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    out_residue = (state_q == DONE) ? acc_q : '0;
  end

`ifdef MOD53_ZERO_FLAG_EN
  // Divisibility flag is meaningful only while a residue is being presented.
  always_comb begin
    out_zero = (state_q == DONE) && (acc_q == '0);
  end
`endif

  // Next-state: latch operand on accept, fold one digit per BUSY cycle, hold result in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = BUSY;
          shreg_d = in_data;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        shreg_d = shreg_q << DIGIT_W;
        acc_d   = reduce_lt159(step_sum);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_mod53_serial_reducer.sv
// Testbench for mod53_serial_reducer: directed cases plus a random scoreboard run.
// Build with +define+MOD53_ZERO_FLAG_EN to also cover the out_zero flag.
module tb_mod53_serial_reducer;

  localparam int DATA_W = 36;
  localparam int NDIG   = DATA_W / 6;
  localparam int N_RAND = 2000;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_residue;
`ifdef MOD53_ZERO_FLAG_EN
  logic              out_zero;
`endif

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  logic [5:0] exp_q[$];

  mod53_serial_reducer #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef MOD53_ZERO_FLAG_EN
    .out_zero    (out_zero),
`endif
    .out_residue (out_residue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and counts/reports a failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge with inputs settled: scores both handshakes, then advances one cycle.
  task automatic step();
    logic [5:0] e;
    if (in_valid && in_ready) begin
      exp_q.push_back(6'(in_data % 36'd53));
      accepts++;
    end
    if (out_valid && out_ready) begin
      checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("residue", 64'(out_residue), 64'(e));
`ifdef MOD53_ZERO_FLAG_EN
        checkOutput("out_zero", 64'(out_zero), 64'(e == 6'd0));
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one operand end to end, checking latency; optionally stalls in DONE for hold cycles.
  task automatic applyStimulus(input logic [DATA_W-1:0] value, input string tag, input int hold);
    int lat;
    logic [5:0] held;
    in_data   = value;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_data  = DATA_W'({$urandom(), $urandom()});
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NDIG));
    if (hold > 0) begin
      out_ready = 1'b0;
      held = exp_q.size() != 0 ? exp_q[0] : 6'd0;
      for (int i = 0; i < hold; i++) begin
        in_valid = ~in_valid;
        in_data  = DATA_W'({$urandom(), $urandom()});
        checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_hold_residue"}, 64'(out_residue), 64'(held));
        checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    checkOutput({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_residue", 64'(out_residue), 64'd0);
`ifdef MOD53_ZERO_FLAG_EN
    checkOutput("rst_out_zero", 64'(out_zero), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operands");
    applyStimulus(36'd53, "op53", 0);
    applyStimulus(36'd500, "op500", 0);
    applyStimulus(36'd64, "op64", 0);
    applyStimulus(36'd0, "op0", 0);
    applyStimulus({DATA_W{1'b1}}, "opmax", 0);

    $display("[TB] stall in DONE with in_valid toggling");
    applyStimulus(36'd123456789, "stall", 10);

    $display("[TB] reset during BUSY");
    in_data  = 36'd987654321;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_residue", 64'(out_residue), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(36'd106, "post_rst", 0);

    $display("[TB] random operands");
    accepts = 0;
    cyc = 0;
    while (accepts < N_RAND && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = DATA_W'({$urandom(), $urandom()});
      out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    checkOutput("rand_accepts", 64'(accepts), 64'(N_RAND));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
